seg7_rx_checker: RTL and testbench

Receive-side checker for the seven-segment output path. It samples a 7-bit segment bus (a..g, active high, bit0 = a) and debounces it. It decodes stable patterns back to a digit 0–9 and checks that successive digits follow the up-count 0→9→0. It also measures the clock-cycle period between digit changes. It sits on the input pins (`ui_in[6:0]`) of a bench or loopback build, observing the display driver of another tile or the team's own seconds counter.

---
 rtl/seg7_rx_checker.sv | 169 ++++++++++++++++
 tb/tb_seg7_rx_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_rx_checker.sv
// seg7_rx_checker
// Receive-side checker for a seven-segment display bus. It samples the
// segment lines, waits until a pattern has been steady for STABLE_CYCLES
// edges, and decodes it to a digit. Each newly accepted digit must be the
// previous one plus 1 mod 10. It also measures the cycles between digit
// changes.
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset
//   segments[6:0] segment bus, bit0 = a .. bit6 = g, active high
//   digit[3:0]    last accepted decoded digit
//   digit_valid   one-cycle pulse when a new digit is accepted
//   pattern_err   one-cycle pulse when a stable pattern is not a legal glyph
//   seq_err       one-cycle pulse when an accepted digit breaks the up-count
//   err_count[7:0] saturating count of pattern_err/seq_err cycles
//   period[23:0]  cycles between the last two digit_valid pulses
//   period_valid  high once period holds a real measurement
//
// state | meaning
// IDLE  | no legal digit seen since reset, sequence check disabled
// TRACK | a previous digit exists, sequence check active

module seg7_rx_checker #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  segments,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic        pattern_err,
    output logic        seq_err,
    output logic [7:0]  err_count,
    output logic [23:0] period,
    output logic        period_valid
);

    localparam logic [7:0]  RUN_MAX   = 8'(STABLE_CYCLES);
    localparam logic [7:0]  RUN_STABLE = 8'(STABLE_CYCLES - 1);
    localparam logic [23:0] PCNT_MAX  = 24'hFF_FFFF;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [6:0]  s_q;
    logic [6:0]  last_acc;
    logic [7:0]  run;
    logic [23:0] pcnt;

    logic        match;
    logic        stable;
    logic        accept;
    logic        legal;
    logic        blank;
    logic [3:0]  value;
    logic [3:0]  expect_next;
    logic        dv_d;
    logic        pe_d;
    logic        se_d;

    // Glyph decode of the sampled pattern.
    always_comb begin
        value = 4'd0;
        legal = 1'b0;
        case (s_q)
            7'h3F: begin value = 4'd0; legal = 1'b1; end
            7'h06: begin value = 4'd1; legal = 1'b1; end
            7'h5B: begin value = 4'd2; legal = 1'b1; end
            7'h4F: begin value = 4'd3; legal = 1'b1; end
            7'h66: begin value = 4'd4; legal = 1'b1; end
            7'h6D: begin value = 4'd5; legal = 1'b1; end
            7'h7C: begin value = 4'd6; legal = 1'b1; end
            7'h07: begin value = 4'd7; legal = 1'b1; end
            7'h7F: begin value = 4'd8; legal = 1'b1; end
            7'h67: begin value = 4'd9; legal = 1'b1; end
            default: begin value = 4'd0; legal = 1'b0; end
        endcase
    end

    // run sits at STABLE_CYCLES-1 for exactly one cycle per steady episode.
    // Therefore the decision is registered one edge after the pattern has
    // been seen on N edges. The decision acts on s_q, so a change on that
    // edge does not cancel it.
    always_comb begin
        match       = (segments == s_q);
        blank       = (s_q == 7'h00);
        stable      = (run == RUN_STABLE);
        accept      = stable && (s_q != last_acc);
        expect_next = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        dv_d        = accept && legal;
        pe_d        = accept && !legal && !blank;
        se_d        = dv_d && (state_q == TRACK) && (value != expect_next);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dv_d) state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q          <= 7'h00;
            run          <= 8'd0;
            last_acc     <= 7'h00;
            pcnt         <= 24'd0;
            digit        <= 4'd0;
            digit_valid  <= 1'b0;
            pattern_err  <= 1'b0;
            seq_err      <= 1'b0;
            err_count    <= 8'd0;
            period       <= 24'd0;
            period_valid <= 1'b0;
        end else begin
            s_q <= segments;

            if (!match) begin
                run <= 8'd0;
            end else if (run < RUN_MAX) begin
                run <= run + 8'd1;
            end

            if (accept) begin
                last_acc <= s_q;
            end

            digit_valid <= dv_d;
            pattern_err <= pe_d;
            seq_err     <= se_d;

            if (dv_d) begin
                digit <= value;
            end

            if ((pe_d || se_d) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            // The first digit after reset only restarts the count.
            if (dv_d) begin
                pcnt <= 24'd1;
                if (state_q == TRACK) begin
                    period       <= pcnt;
                    period_valid <= 1'b1;
                end
            end else if (pcnt != PCNT_MAX) begin
                pcnt <= pcnt + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_rx_checker.sv
// tb_seg7_rx_checker
// Directed bench for seg7_rx_checker with STABLE_CYCLES = 4. Each hold drives
// one pattern for a number of cycles and records the pulses seen. The
// recorded values are then compared against hand-computed expectations.

module tb_seg7_rx_checker;

    logic        clk;
    logic        reset;
    logic [6:0]  segments;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        pattern_err;
    logic        seq_err;
    logic [7:0]  err_count;
    logic [23:0] period;
    logic        period_valid;

    int tests_run = 0;
    int tests_failed = 0;

    // Per-hold observations.
    int dv_cnt;
    int dv_at;
    int dv_dig;
    int se_cnt;
    int se_with_dv;
    int pe_cnt;
    int pe_at;
    int tot_pe;

    seg7_rx_checker #(.STABLE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .segments     (segments),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .pattern_err  (pattern_err),
        .seq_err      (seq_err),
        .err_count    (err_count),
        .period       (period),
        .period_valid (period_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after n sampled cycles.
    task automatic hold(input logic [6:0] pat, input int n);
        dv_cnt = 0; dv_at = 0; dv_dig = -1; se_cnt = 0; se_with_dv = 0;
        pe_cnt = 0; pe_at = 0;
        segments = pat;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (digit_valid) begin
                dv_cnt++;
                dv_at  = i;
                dv_dig = int'(digit);
                if (seq_err) se_with_dv++;
            end
            if (seq_err) se_cnt++;
            if (pattern_err) begin
                pe_cnt++;
                pe_at = i;
            end
        end
    endtask

    task automatic do_reset();
        segments = 7'h00;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        segments = 7'h00;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_dv", 32'(digit_valid), 32'd0);
        chk("rst_pe", 32'(pattern_err), 32'd0);
        chk("rst_se", 32'(seq_err), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        chk("rst_period", 32'(period), 32'd0);
        chk("rst_pvalid", 32'(period_valid), 32'd0);

        // Clean count 0,1,2
        hold(7'h3F, 10);
        chk("clean0_cnt", 32'(dv_cnt), 32'd1);
        chk("clean0_at", 32'(dv_at), 32'd5);
        chk("clean0_dig", 32'(dv_dig), 32'd0);
        chk("clean0_pvalid", 32'(period_valid), 32'd0);
        hold(7'h06, 10);
        chk("clean1_cnt", 32'(dv_cnt), 32'd1);
        chk("clean1_at", 32'(dv_at), 32'd5);
        chk("clean1_dig", 32'(dv_dig), 32'd1);
        hold(7'h5B, 10);
        chk("clean2_cnt", 32'(dv_cnt), 32'd1);
        chk("clean2_at", 32'(dv_at), 32'd5);
        chk("clean2_dig", 32'(dv_dig), 32'd2);
        chk("clean_se", 32'(se_cnt), 32'd0);
        chk("clean_errcnt", 32'(err_count), 32'd0);
        chk("clean_period", 32'(period), 32'd10);
        chk("clean_pvalid", 32'(period_valid), 32'd1);

        // Glitch rejection
        do_reset();
        hold(7'h06, 10);
        chk("glitch_first", 32'(dv_dig), 32'd1);
        hold(7'h7F, 3);
        chk("glitch_dv", 32'(dv_cnt), 32'd0);
        chk("glitch_pe", 32'(pe_cnt), 32'd0);
        hold(7'h06, 10);
        chk("glitch_return_dv", 32'(dv_cnt), 32'd0);

        // Sequence error 1 -> 3, then 4 is fine
        hold(7'h4F, 10);
        chk("seq_dig", 32'(dv_dig), 32'd3);
        chk("seq_se_same", 32'(se_with_dv), 32'd1);
        chk("seq_se_total", 32'(se_cnt), 32'd1);
        chk("seq_errcnt", 32'(err_count), 32'd1);
        hold(7'h66, 10);
        chk("seq4_dig", 32'(dv_dig), 32'd4);
        chk("seq4_se", 32'(se_cnt), 32'd0);
        chk("seq4_errcnt", 32'(err_count), 32'd1);

        // Illegal pattern, then 8 -> 9 is still in sequence
        do_reset();
        hold(7'h7F, 10);
        chk("ill8_dig", 32'(dv_dig), 32'd8);
        hold(7'h01, 8);
        chk("ill_pe_cnt", 32'(pe_cnt), 32'd1);
        chk("ill_pe_at", 32'(pe_at), 32'd5);
        chk("ill_dv", 32'(dv_cnt), 32'd0);
        chk("ill_digit", 32'(digit), 32'd8);
        chk("ill_errcnt", 32'(err_count), 32'd1);
        hold(7'h67, 10);
        chk("ill9_dig", 32'(dv_dig), 32'd9);
        chk("ill9_se", 32'(se_cnt), 32'd0);
        chk("ill9_period", 32'(period), 32'd18);

        // Wrap through blank
        hold(7'h00, 10);
        chk("blank_dv", 32'(dv_cnt), 32'd0);
        chk("blank_pe", 32'(pe_cnt), 32'd0);
        hold(7'h3F, 10);
        chk("wrap_dig", 32'(dv_dig), 32'd0);
        chk("wrap_se", 32'(se_cnt), 32'd0);
        chk("wrap_period", 32'(period), 32'd20);
        chk("wrap_errcnt", 32'(err_count), 32'd1);
        hold(7'h06, 10);
        chk("wrap1_dig", 32'(dv_dig), 32'd1);

        // Saturation: 300 alternating illegal patterns
        tot_pe = 0;
        for (int k = 0; k < 300; k++) begin
            hold((k % 2 == 0) ? 7'h01 : 7'h02, 5);
            tot_pe += pe_cnt;
        end
        chk("sat_pe_total", 32'(tot_pe), 32'd300);
        chk("sat_errcnt", 32'(err_count), 32'd255);
        chk("sat_digit", 32'(digit), 32'd1);

        // Reset in the middle of a partial run
        hold(7'h06, 2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_digit", 32'(digit), 32'd0);
        chk("mid_dv", 32'(digit_valid), 32'd0);
        chk("mid_pe", 32'(pattern_err), 32'd0);
        chk("mid_se", 32'(seq_err), 32'd0);
        chk("mid_errcnt", 32'(err_count), 32'd0);
        chk("mid_period", 32'(period), 32'd0);
        chk("mid_pvalid", 32'(period_valid), 32'd0);
        hold(7'h06, 10);
        chk("post_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("post_dig", 32'(dv_dig), 32'd1);
        chk("post_se", 32'(se_cnt), 32'd0);
        chk("post_errcnt", 32'(err_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
